// File: rtl/mmio_pkg.sv
// MMIO controller constants: region nibble, register map, control bits.
// Also holds the access decoder shared by the controller.
package mmio_pkg;

  localparam logic [3:0]  MMIO_REGION = 4'h8;

  localparam logic [31:0] ADDR_CTRL = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX   = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX   = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYC  = 32'h8000_0010;
  localparam logic [31:0] ADDR_INST = 32'h8000_0014;
  localparam logic [31:0] ADDR_CRST = 32'h8000_0018;

  localparam int CTRL_TX_RDY  = 0;
  localparam int CTRL_RX_FULL = 1;
  localparam int CTRL_TX_OVF  = 2;

  typedef struct packed {
    logic hit;
    logic rd_any;
    logic rd_ctrl;
    logic rd_rx;
    logic rd_cyc;
    logic rd_inst;
    logic wr_tx;
    logic wr_crst;
  } mmio_dec_t;

  function automatic logic word_hit(
    input logic [31:0] a,
    input logic [31:0] base
  );
    return ((a ^ base) & 32'hFFFF_FFFC) == 32'h0;
  endfunction

  function automatic mmio_dec_t mmio_decode(
    input logic [31:0] a,
    input logic        valid,
    input logic        load,
    input logic        store
  );
    mmio_dec_t d;
    logic      ld;
    logic      st;
    d       = '0;
    d.hit   = (a[31:28] == MMIO_REGION);
    ld      = valid & load & d.hit;
    st      = valid & store & d.hit;
    d.rd_any  = ld;
    d.rd_ctrl = ld & word_hit(a, ADDR_CTRL);
    d.rd_rx   = ld & word_hit(a, ADDR_RX);
    d.rd_cyc  = ld & word_hit(a, ADDR_CYC);
    d.rd_inst = ld & word_hit(a, ADDR_INST);
    d.wr_tx   = st & word_hit(a, ADDR_TX);
    d.wr_crst = st & word_hit(a, ADDR_CRST);
    return d;
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// X/M access bus, retire strobe and UART byte handshakes of mmio_ctrl.
// slave = controller side, master = core/UART side.
interface mmio_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              xm_valid;
  logic              xm_load;
  logic              xm_store;
  logic [ADDR_W-1:0] xm_addr;
  logic [DATA_W-1:0] xm_wdata;
  logic              w_retire;

  logic [7:0]        uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ready;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_valid;
  logic              uart_tx_ready;

  logic              mmio_sel;
  logic [DATA_W-1:0] mmio_rdata;

  modport slave (
    input  xm_valid,
    input  xm_load,
    input  xm_store,
    input  xm_addr,
    input  xm_wdata,
    input  w_retire,
    input  uart_rx_data,
    input  uart_rx_valid,
    output uart_rx_ready,
    output uart_tx_data,
    output uart_tx_valid,
    input  uart_tx_ready,
    output mmio_sel,
    output mmio_rdata
  );

  modport master (
    output xm_valid,
    output xm_load,
    output xm_store,
    output xm_addr,
    output xm_wdata,
    output w_retire,
    output uart_rx_data,
    output uart_rx_valid,
    input  uart_rx_ready,
    input  uart_tx_data,
    input  uart_tx_valid,
    output uart_tx_ready,
    input  mmio_sel,
    input  mmio_rdata
  );

endinterface

// File: rtl/mmio_byte_buf.sv
// One-entry byte buffer. Push wins over pop so a same-cycle
// refill keeps the entry full with the new byte.
module mmio_byte_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic [7:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= 8'h00;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: UART RX/TX byte buffers, cycle/instret counters
// and registered load data for the W stage.
module mmio_ctrl
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mmio_ctrl_if.slave  bus
);

  mmio_dec_t   dec;
  logic        rx_full;
  logic [7:0]  rx_byte;
  logic        rx_hs;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic        tx_hs;
  logic        tx_push;
  logic        tx_ovf;
  logic        tx_ovf_set;
  logic [31:0] cyc_cnt;
  logic [31:0] inst_cnt;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^bus.xm_wdata[31:8];

  always_comb begin
    dec = mmio_decode(bus.xm_addr, bus.xm_valid,
                      bus.xm_load, bus.xm_store);
  end

  assign bus.mmio_sel = dec.hit & bus.xm_valid
                      & (bus.xm_load | bus.xm_store);

  assign rx_hs = bus.uart_rx_valid & ~rx_full;

  mmio_byte_buf u_rx_buf (
    .clk       (clk),
    .rst_n     (rst),
    .push      (rx_hs),
    .push_data (bus.uart_rx_data),
    .pop       (dec.rd_rx),
    .full      (rx_full),
    .data      (rx_byte)
  );

  assign bus.uart_rx_ready = ~rx_full;

  // A store landing in the drain cycle refills the slot, not an overflow.
  assign tx_hs      = tx_full & bus.uart_tx_ready;
  assign tx_push    = dec.wr_tx & (~tx_full | tx_hs);
  assign tx_ovf_set = dec.wr_tx & tx_full & ~bus.uart_tx_ready;

  mmio_byte_buf u_tx_buf (
    .clk       (clk),
    .rst_n     (rst),
    .push      (tx_push),
    .push_data (bus.xm_wdata[7:0]),
    .pop       (tx_hs),
    .full      (tx_full),
    .data      (tx_byte)
  );

  assign bus.uart_tx_valid = tx_full;
  assign bus.uart_tx_data  = tx_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
    end else if (dec.wr_crst) begin
      tx_ovf <= 1'b0;
    end else if (tx_ovf_set) begin
      tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt  <= 32'h0;
      inst_cnt <= 32'h0;
    end else if (dec.wr_crst) begin
      cyc_cnt  <= 32'h0;
      inst_cnt <= 32'h0;
    end else begin
      cyc_cnt  <= cyc_cnt + 32'h1;
      inst_cnt <= inst_cnt + {31'h0, bus.w_retire};
    end
  end

  always_comb begin
    rd_val = 32'h0;
    unique case (1'b1)
      dec.rd_ctrl: begin
        rd_val[CTRL_TX_RDY]  = ~tx_full;
        rd_val[CTRL_RX_FULL] = rx_full;
        rd_val[CTRL_TX_OVF]  = tx_ovf;
      end
      dec.rd_rx:   rd_val = {24'h0, rx_byte};
      dec.rd_cyc:  rd_val = cyc_cnt;
      dec.rd_inst: rd_val = inst_cnt;
      default:     rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mmio_rdata <= 32'h0;
    end else if (dec.rd_any) begin
      bus.mmio_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: UART buffers, counters, decode,
// overflow, counter wrap and asynchronous reset.
module tb_mmio_ctrl;
  import mmio_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int unsigned ncyc;
  logic [31:0] e;

  mmio_ctrl_if bus ();

  mmio_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc = ncyc + 1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a);
    bus.xm_valid = 1'b1;
    bus.xm_load  = 1'b1;
    bus.xm_store = 1'b0;
    bus.xm_addr  = a;
    tick();
    bus.xm_valid = 1'b0;
    bus.xm_load  = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d);
    bus.xm_valid = 1'b1;
    bus.xm_load  = 1'b0;
    bus.xm_store = 1'b1;
    bus.xm_addr  = a;
    bus.xm_wdata = d;
    tick();
    bus.xm_valid = 1'b0;
    bus.xm_store = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ncyc     = 0;
    rst_n    = 1'b0;
    bus.xm_valid      = 1'b0;
    bus.xm_load       = 1'b0;
    bus.xm_store      = 1'b0;
    bus.xm_addr       = 32'h0;
    bus.xm_wdata      = 32'h0;
    bus.w_retire      = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_valid = 1'b0;
    bus.uart_tx_ready = 1'b0;
    tick();
    tick();
    chk("rst_rdata", bus.mmio_rdata, 32'h0);
    chk("rst_rx_ready", bus.uart_rx_ready, 1'b1);
    chk("rst_tx_valid", bus.uart_tx_valid, 1'b0);
    chk("rst_tx_data", bus.uart_tx_data, 8'h00);

    rst_n = 1'b1;
    ncyc  = 0;
    repeat (100) tick();
    e = ncyc;
    do_load(ADDR_CYC);
    chk("cyc_100", bus.mmio_rdata, 32'd100);
    chk("cyc_model", bus.mmio_rdata, e);
    chk("idle_rx_ready", bus.uart_rx_ready, 1'b1);
    do_load(ADDR_INST);
    chk("inst_idle", bus.mmio_rdata, 32'h0);

    bus.xm_valid = 1'b1;
    bus.xm_load  = 1'b1;
    bus.xm_addr  = 32'h8000_0014;
    #1;
    chk("sel_hit", bus.mmio_sel, 1'b1);
    bus.xm_addr  = 32'h4000_0010;
    #1;
    chk("sel_miss", bus.mmio_sel, 1'b0);
    bus.xm_valid = 1'b0;
    #1;
    bus.xm_addr  = 32'h8000_0010;
    #1;
    chk("sel_invalid", bus.mmio_sel, 1'b0);
    bus.xm_load  = 1'b0;

    bus.uart_rx_data  = 8'h5A;
    bus.uart_rx_valid = 1'b1;
    tick();
    bus.uart_rx_valid = 1'b0;
    chk("rx_ready_drop", bus.uart_rx_ready, 1'b0);
    do_load(ADDR_CTRL);
    chk("ctrl_rx_full", bus.mmio_rdata, 32'h3);
    do_load(ADDR_RX);
    chk("rx_byte_5a", bus.mmio_rdata, 32'h5A);
    chk("rx_ready_back", bus.uart_rx_ready, 1'b1);
    do_load(ADDR_CTRL);
    chk("ctrl_rx_clr", bus.mmio_rdata, 32'h1);
    do_load(32'h4000_0010);
    chk("nonregion_hold", bus.mmio_rdata, 32'h1);
    do_load(32'h8000_000C);
    chk("unmapped_rd", bus.mmio_rdata, 32'h0);

    bus.uart_rx_data  = 8'h6B;
    bus.uart_rx_valid = 1'b1;
    do_load(ADDR_RX);
    bus.uart_rx_valid = 1'b0;
    chk("rx_same_old", bus.mmio_rdata, 32'h5A);
    chk("rx_same_full", bus.uart_rx_ready, 1'b0);
    do_load(ADDR_RX);
    chk("rx_same_new", bus.mmio_rdata, 32'h6B);
    chk("rx_same_clr", bus.uart_rx_ready, 1'b1);

    bus.uart_tx_ready = 1'b0;
    do_store(ADDR_TX, 32'h0000_0041);
    chk("tx_valid_41", bus.uart_tx_valid, 1'b1);
    chk("tx_data_41", bus.uart_tx_data, 8'h41);
    do_store(ADDR_TX, 32'hFFFF_FF42);
    chk("tx_keep_41", bus.uart_tx_data, 8'h41);
    do_load(ADDR_CTRL);
    chk("ctrl_ovf", bus.mmio_rdata, 32'h4);
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    chk("tx_drain", bus.uart_tx_valid, 1'b0);

    do_store(ADDR_CRST, 32'h0);
    do_load(ADDR_CTRL);
    chk("ctrl_ovf_clr", bus.mmio_rdata, 32'h1);
    do_store(ADDR_TX, 32'h44);
    chk("tx_data_44", bus.uart_tx_data, 8'h44);
    bus.uart_tx_ready = 1'b1;
    do_store(ADDR_TX, 32'h43);
    chk("tx_refill_vld", bus.uart_tx_valid, 1'b1);
    chk("tx_refill_43", bus.uart_tx_data, 8'h43);
    do_load(ADDR_CTRL);
    bus.uart_tx_ready = 1'b0;
    chk("ctrl_hs_noovf", bus.mmio_rdata, 32'h0);
    chk("tx_hs_drain", bus.uart_tx_valid, 1'b0);

    do_store(ADDR_TX, 32'h45);
    do_store(ADDR_TX, 32'h46);
    do_load(ADDR_CTRL);
    chk("ctrl_ovf2", bus.mmio_rdata, 32'h4);
    bus.w_retire = 1'b1;
    repeat (7) tick();
    bus.w_retire = 1'b0;
    do_load(ADDR_INST);
    chk("inst_7", bus.mmio_rdata, 32'd7);
    bus.w_retire = 1'b1;
    do_store(ADDR_CRST, 32'h0);
    bus.w_retire = 1'b0;
    ncyc = 0;
    do_load(ADDR_CYC);
    chk("cyc_crst", bus.mmio_rdata, 32'h0);
    do_load(ADDR_INST);
    chk("inst_crst", bus.mmio_rdata, 32'h0);
    do_load(ADDR_CTRL);
    chk("ctrl_crst_ovf", bus.mmio_rdata, 32'h0);
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;

    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    do_load(ADDR_CYC);
    chk("cyc_max", bus.mmio_rdata, 32'hFFFF_FFFF);
    do_load(ADDR_CYC);
    chk("cyc_wrap", bus.mmio_rdata, 32'h0);
    ncyc = 1;

    bus.xm_valid = 1'b0;
    bus.xm_store = 1'b1;
    bus.xm_addr  = ADDR_TX;
    bus.xm_wdata = 32'h77;
    tick();
    bus.xm_addr  = ADDR_CRST;
    tick();
    bus.xm_store = 1'b0;
    chk("novalid_tx", bus.uart_tx_valid, 1'b0);
    e = ncyc;
    do_load(ADDR_CYC);
    chk("novalid_crst", bus.mmio_rdata, e);

    bus.uart_rx_data  = 8'hA5;
    bus.uart_rx_valid = 1'b1;
    tick();
    bus.uart_rx_valid = 1'b0;
    do_store(ADDR_TX, 32'h50);
    chk("pre_rst_tx", bus.uart_tx_valid, 1'b1);
    chk("pre_rst_rx", bus.uart_rx_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", bus.uart_tx_valid, 1'b0);
    chk("arst_rx_ready", bus.uart_rx_ready, 1'b1);
    chk("arst_rdata", bus.mmio_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_tx", bus.uart_tx_data, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller for the 3-stage RISC-V core. It decodes X/M-stage loads and stores that target the MMIO region and buffers UART RX/TX bytes behind one-entry ready/valid handshakes. It maintains the cycle and retired-instruction counters, including the reset-counters command. It returns registered read data so the W stage can select it as the UART or counter writeback source.

## Interface
- `ADDR_W`, 32, X/M address width
- `DATA_W`, 32, load/store data width
- `clk`  in  1  core clock
- `rst`  in  1  reset: one clock; reset is asynchronous and active-low
- `xm_valid`  in  1  X/M instruction is live (not flushed, not a bubble)
- `xm_load`  in  1  X/M instruction is a load
- `xm_store`  in  1  X/M instruction is a store
- `xm_addr`  in  ADDR_W  ALU-computed effective address
- `xm_wdata`  in  DATA_W  store data (rs2 after forwarding)
- `w_retire`  in  1  a non-bubble instruction is in W this cycle
- `uart_rx_data`  in  8  byte from UART receiver
- `uart_rx_valid`  in  1  receiver offers a byte
- `uart_rx_ready`  out  1  controller accepts the byte
- `uart_tx_data`  out  8  byte to UART transmitter
- `uart_tx_valid`  out  1  controller offers a byte
- `uart_tx_ready`  in  1  transmitter accepts the byte
- `mmio_sel`  out  1  X/M access hits the MMIO region (combinational)
- `mmio_rdata`  out  DATA_W  registered load data for W

## Operation
- Region hit: `xm_addr[31:28] == 4'h8`. Side effects occur only when `xm_valid` is high.
- Address map (word-aligned; `xm_addr[1:0]` ignored):
  - 0x80000000 R: control `{29'b0, tx_ovf, rx_full, !tx_full}`
  - 0x80000004 R: `{24'b0, rx_byte}`; clears `rx_full`
  - 0x80000008 W: TX byte `xm_wdata[7:0]`
  - 0x80000010 R: cycle counter
  - 0x80000014 R: instruction counter
  - 0x80000018 W: reset both counters and clear `tx_ovf`
  - Unmapped MMIO reads return 0. Unmapped writes are ignored.
- RX buffer, one entry:
  - `uart_rx_ready = !rx_full`.
  - A handshake latches `rx_byte` and sets `rx_full`.
  - A read of 0x80000004 in the same cycle as a handshake returns the old byte. The new byte is captured and `rx_full` stays 1.
- TX buffer, one entry:
  - `uart_tx_valid = tx_full`.
  - A store to 0x80000008 with `!tx_full` latches the byte and sets `tx_full`.
  - A store with `tx_full` is dropped and sets sticky `tx_ovf`.
  - A handshake clears `tx_full`. A store in the same cycle as the handshake is accepted: `tx_full` stays 1 and the new byte is presented.
- Counters, 32-bit, wrap from 0xFFFFFFFF to 0:
  - `cyc_cnt` increments every cycle.
  - `inst_cnt` increments when `w_retire` is high.
  - A reset-counters store forces both counters to 0 on the next edge. Reset wins over a simultaneous increment.

## Timing
- Reset values:
  - `rx_full`, `tx_full`, `tx_ovf` = 0
  - `rx_byte`, `tx_byte` = 0
  - `cyc_cnt`, `inst_cnt` = 0
  - `mmio_rdata` = 0
  - `uart_rx_ready` = 1, `uart_tx_valid` = 0
- Reset asserted mid-handshake discards any buffered byte.
- Read latency is 1 cycle. `mmio_rdata` is captured at the edge ending the load's X/M cycle and holds until the next MMIO load. Counter reads return the value from that X/M cycle.
- Status reads see pre-edge state. A control read in the cycle of a TX handshake still reports `!tx_full = 0`.
- `uart_rx_ready` and `uart_tx_valid` are direct register functions with no input-to-output combinational path. `mmio_sel` is the only combinational output.

## Structure
- `mmio_pkg`: region nibble, the six address constants, control-bit indices.
- Sub-module `mmio_byte_buf`: one-entry 8-bit ready/valid buffer with push/pop/full. Instantiate it twice (RX, TX). Overflow detection stays in the top level.

## Test plan
- Reset, then idle 100 cycles; load 0x80000010 → `mmio_rdata` = 100 ± pipeline offset, exact value checked against bench model; `uart_rx_ready` = 1.
- Drive `uart_rx_valid` with 0x5A → `uart_rx_ready` drops; load 0x80000000 → bit1 = 1; load 0x80000004 → 0x0000005A, `rx_full` cleared next cycle.
- Store 0x41, then 0x42, to 0x80000008 with `uart_tx_ready` = 0 → `uart_tx_data` = 0x41, control bit2 (`tx_ovf`) = 1; raise ready → `tx_valid` drops.
- Store 0x43 in the same cycle `uart_tx_ready` completes a handshake → 0x43 presented next cycle, no overflow.
- Retire 7 instructions, store to 0x80000018 in the same cycle as a retire → both counters read 0 immediately after; `tx_ovf` cleared.
- Preload `cyc_cnt` near 0xFFFFFFFF via force, step → wraps to 0. Assert reset with `tx_full` = 1 → `uart_tx_valid` = 0 asynchronously. Store with `xm_valid` = 0 → no side effect.
